// File: rtl/mask_b_shift_unit.sv
// Iterative boolean-masked shift/rotate unit (SLLI/SRLI/RORI) on a two-share operand.
// One power-of-two stage per cycle keeps latency fixed at SHW+1 regardless of shamt.

module mask_b_shift_stage #(
  parameter int XLEN = 32,
  parameter int SHW  = 5,
  parameter int STW  = 3
) (
  input  logic [XLEN-1:0] din,
  input  logic [STW-1:0]  step,
  input  logic            en,
  input  logic            sll,
  input  logic            srl,
  input  logic            ror,
  output logic [XLEN-1:0] dout
);
  logic [SHW-1:0][XLEN-1:0] c_sll, c_srl, c_ror;

  // Fixed-distance candidates for every stage; step selects one, so no barrel shifter.
  for (genvar k = 0; k < SHW; k++) begin : g_dist
    localparam int D = 1 << k;
    assign c_sll[k] = din << D;
    assign c_srl[k] = din >> D;
    assign c_ror[k] = (din >> D) | (din << (XLEN - D));
  end

  always_comb begin
    dout = din;
    for (int k = 0; k < SHW; k++) begin
      if (en && step == STW'(k)) begin
        if (ror)      dout = c_ror[k];
        else if (srl) dout = c_srl[k];
        else if (sll) dout = c_sll[k];
      end
    end
  end
endmodule

module mask_b_shift_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            valid,
  input  logic            op_slli,
  input  logic            op_srli,
  input  logic            op_rori,
  input  logic [SHW-1:0]  shamt,
  input  logic [XLEN-1:0] rs1_s0,
  input  logic [XLEN-1:0] rs1_s1,
  input  logic [XLEN-1:0] prng,
  output logic            ready,
  output logic [XLEN-1:0] rd_s0,
  output logic [XLEN-1:0] rd_s1
);
  localparam int NSH = 2;
  localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  typedef struct packed {
    logic sll;
    logic srl;
    logic ror;
  } op_t;

  state_e                    state_q, state_d;
  logic [STW-1:0]            step_q;
  logic [NSH-1:0][XLEN-1:0]  sh_q, sh_d, rd_q;
  logic [XLEN-1:0]           prng_q;
  logic [SHW-1:0]            shamt_q;
  op_t                       op_q, op_in;
  logic                      stage_en, last;

  // Op priority resolved once at accept: rori > srli > slli, none = pass-through.
  always_comb begin
    op_in.ror = op_rori;
    op_in.srl = op_srli & ~op_rori;
    op_in.sll = op_slli & ~op_srli & ~op_rori;
  end

  always_comb begin
    stage_en = 1'b0;
    for (int k = 0; k < SHW; k++)
      if (step_q == STW'(k)) stage_en = shamt_q[k];
  end

  assign last = (step_q == STW'(SHW - 1));

  // Each share goes through its own stage instance; shares never meet.
  for (genvar i = 0; i < NSH; i++) begin : g_share
    mask_b_shift_stage #(.XLEN(XLEN), .SHW(SHW), .STW(STW)) u_stage (
      .din  (sh_q[i]),
      .step (step_q),
      .en   (stage_en),
      .sll  (op_q.sll),
      .srl  (op_q.srl),
      .ror  (op_q.ror),
      .dout (sh_d[i])
    );
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid && !flush) state_d = ST_SHIFT;
      ST_SHIFT: if (flush) state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      step_q  <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      prng_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
    end else if (flush) begin
      step_q  <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      prng_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rd_q <= '0;
          if (valid) begin
            sh_q[0] <= rs1_s0;
            sh_q[1] <= rs1_s1;
            prng_q  <= prng;
            shamt_q <= shamt;
            op_q    <= op_in;
            step_q  <= '0;
          end
        end
        ST_SHIFT: begin
          sh_q   <= sh_d;
          step_q <= step_q + 1'b1;
          if (last) begin
            rd_q[0] <= sh_d[0] ^ prng_q;
            rd_q[1] <= sh_d[1] ^ prng_q;
          end
        end
        ST_DONE: begin
          rd_q   <= '0;
          sh_q   <= '0;
          step_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated so a flush landing in DONE never exposes a result.
  assign ready = (state_q == ST_DONE) && !flush;
  assign rd_s0 = ready ? rd_q[0] : '0;
  assign rd_s1 = ready ? rd_q[1] : '0;
endmodule

// File: tb/tb_mask_b_shift_unit.sv
// Randomized self-checking bench for mask_b_shift_unit against a per-share arithmetic model.

module tb_mask_b_shift_unit;
  logic        g_clk = 1'b0;
  logic        g_resetn, flush, valid, op_slli, op_srli, op_rori;
  logic [4:0]  shamt;
  logic [31:0] rs1_s0, rs1_s1, prng;
  logic        ready;
  logic [31:0] rd_s0, rd_s1;

  int tests = 0;
  int fails = 0;

  mask_b_shift_unit #(.XLEN(32), .SHW(5)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .valid(valid),
    .op_slli(op_slli), .op_srli(op_srli), .op_rori(op_rori), .shamt(shamt),
    .rs1_s0(rs1_s0), .rs1_s1(rs1_s1), .prng(prng),
    .ready(ready), .rd_s0(rd_s0), .rd_s1(rd_s1)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic sl, sr, ro,
                                            input int s);
    if (ro)      return (x >> s) | (x << (32 - s));
    else if (sr) return x >> s;
    else if (sl) return x << s;
    else         return x;
  endfunction

  // Issues one request, holds valid until ready, checks gating, latency and result.
  task automatic do_op(input logic sl, sr, ro, input logic [4:0] sa,
                       input logic [31:0] a0, a1, p, output logic [31:0] r0, r1);
    logic [31:0] e0, e1, ex;
    int lat;
    e0 = ref_shift(a0, sl, sr, ro, int'(sa)) ^ p;
    e1 = ref_shift(a1, sl, sr, ro, int'(sa)) ^ p;
    ex = ref_shift(a0 ^ a1, sl, sr, ro, int'(sa));
    r0 = '0; r1 = '0;
    @(negedge g_clk);
    valid = 1'b1; op_slli = sl; op_srli = sr; op_rori = ro; shamt = sa;
    rs1_s0 = a0; rs1_s1 = a1; prng = p;
    @(posedge g_clk);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge g_clk);
      if (ready) lat = c;
      else begin
        tests++;
        if (rd_s0 !== 32'h0 || rd_s1 !== 32'h0) begin
          fails++;
          $display("FAIL rd_gating cycle %0d: got %h/%h want 0/0", c, rd_s0, rd_s1);
        end
      end
    end
    valid = 1'b0;
    tests++;
    if (lat !== 6) begin
      fails++;
      $display("FAIL latency: got %0d want 6 (sa=%0d)", lat, sa);
    end
    if (lat != 0) begin
      r0 = rd_s0; r1 = rd_s1;
      tests++;
      if ((rd_s0 ^ rd_s1) !== ex) begin
        fails++;
        $display("FAIL unmasked: got %h want %h (op=%b%b%b sa=%0d)", rd_s0 ^ rd_s1, ex, ro, sr, sl, sa);
      end
      tests++;
      if (rd_s0 !== e0 || rd_s1 !== e1) begin
        fails++;
        $display("FAIL remask: got %h/%h want %h/%h", rd_s0, rd_s1, e0, e1);
      end
    end
  endtask

  task automatic check_idle_quiet(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge g_clk);
      tests++;
      if (ready !== 1'b0 || rd_s0 !== 32'h0 || rd_s1 !== 32'h0) begin
        fails++;
        $display("FAIL %s cycle %0d: got ready=%b rd=%h/%h want 0/0/0", name, c, ready, rd_s0, rd_s1);
      end
    end
  endtask

  task automatic test_reset;
    g_resetn = 1'b0; flush = 1'b0; valid = 1'b0;
    op_slli = 1'b0; op_srli = 1'b0; op_rori = 1'b0; shamt = '0;
    rs1_s0 = '0; rs1_s1 = '0; prng = '0;
    #12;
    tests++;
    if (ready !== 1'b0 || rd_s0 !== 32'h0 || rd_s1 !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got ready=%b rd=%h/%h want 0/0/0", ready, rd_s0, rd_s1);
    end
    @(negedge g_clk);
    g_resetn = 1'b1;
    check_idle_quiet(3, "post_reset");
  endtask

  task automatic test_vectors;
    logic [31:0] r0, r1;
    do_op(1'b1, 1'b0, 1'b0, 5'd4, 32'hDEADBEEF, 32'hDEADBEEE, 32'hFFFFFFFF, r0, r1);
    tests++;
    if (r0 !== 32'h1524110F || r1 !== 32'h1524111F) begin
      fails++;
      $display("FAIL vec_slli: got %h/%h want 1524110F/1524111F", r0, r1);
    end
    do_op(1'b0, 1'b1, 1'b0, 5'd31, 32'hC0000000, 32'h40000000, 32'h12345678, r0, r1);
    tests++;
    if (r0 !== 32'h12345679 || (r0 ^ r1) !== 32'h00000001) begin
      fails++;
      $display("FAIL vec_srli: got %h xor %h want 12345679 xor 00000001", r0, r0 ^ r1);
    end
    do_op(1'b0, 1'b0, 1'b1, 5'd1, 32'h00000003, 32'h00000002, 32'h0, r0, r1);
    tests++;
    if (r0 !== 32'h80000001 || r1 !== 32'h00000001) begin
      fails++;
      $display("FAIL vec_rori: got %h/%h want 80000001/00000001", r0, r1);
    end
    // All op bits set: rotate wins; none set: pass-through with remask.
    do_op(1'b1, 1'b1, 1'b1, 5'd8, 32'h000000F0, 32'h0, 32'h0, r0, r1);
    tests++;
    if (r0 !== 32'hF0000000) begin
      fails++;
      $display("FAIL vec_priority: got %h want F0000000", r0);
    end
    do_op(1'b0, 1'b0, 1'b0, 5'd13, 32'h12345678, 32'h0F0F0F0F, 32'hAAAAAAAA, r0, r1);
    tests++;
    if ((r0 ^ r1) !== (32'h12345678 ^ 32'h0F0F0F0F)) begin
      fails++;
      $display("FAIL vec_pass: got %h want %h", r0 ^ r1, 32'h12345678 ^ 32'h0F0F0F0F);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r0, r1;
    do_op(1'b1, 1'b0, 1'b0, 5'd0, $urandom, $urandom, $urandom, r0, r1);
    do_op(1'b0, 1'b0, 1'b1, 5'd31, $urandom, $urandom, $urandom, r0, r1);
    check_idle_quiet(2, "b2b_tail");
  endtask

  task automatic test_random;
    logic [31:0] r0, r1;
    logic [2:0] ops;
    for (int n = 0; n < 40; n++) begin
      ops = 3'($urandom_range(0, 7));
      do_op(ops[0], ops[1], ops[2], 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, r0, r1);
    end
    check_idle_quiet(1, "rand_tail");
  endtask

  task automatic test_flush;
    logic [31:0] r0, r1;
    @(negedge g_clk);
    valid = 1'b1; op_slli = 1'b1; op_srli = 1'b0; op_rori = 1'b0; shamt = 5'd3;
    rs1_s0 = 32'h1234; rs1_s1 = 32'h5678; prng = 32'hFFFF0000;
    @(posedge g_clk);
    for (int c = 1; c <= 3; c++) @(negedge g_clk);
    valid = 1'b0; flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check_idle_quiet(10, "flush_quiet");
    // flush alongside valid in IDLE must not start an op
    valid = 1'b1; flush = 1'b1;
    @(negedge g_clk);
    valid = 1'b0; flush = 1'b0;
    check_idle_quiet(8, "flush_valid_idle");
    do_op(1'b0, 1'b1, 1'b0, 5'd5, 32'hF00DF00D, 32'h0BADC0DE, 32'h5A5A5A5A, r0, r1);
  endtask

  task automatic test_async_reset;
    logic [31:0] r0, r1;
    @(negedge g_clk);
    valid = 1'b1; op_rori = 1'b1; op_slli = 1'b0; op_srli = 1'b0; shamt = 5'd7;
    rs1_s0 = $urandom; rs1_s1 = $urandom; prng = 32'hC3C3C3C3;
    @(posedge g_clk);
    for (int c = 1; c <= 3; c++) @(negedge g_clk);
    valid = 1'b0;
    #2 g_resetn = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0 || rd_s0 !== 32'h0 || rd_s1 !== 32'h0) begin
      fails++;
      $display("FAIL areset_shift: got ready=%b rd=%h/%h want 0/0/0", ready, rd_s0, rd_s1);
    end
    #1 g_resetn = 1'b1;
    check_idle_quiet(10, "areset_shift_quiet");
    // Reset while the result is being presented must clear it immediately.
    do_op(1'b1, 1'b0, 1'b0, 5'd2, 32'h11111111, 32'h22222222, 32'hFFFFFFFF, r0, r1);
    #1 g_resetn = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0 || rd_s0 !== 32'h0 || rd_s1 !== 32'h0) begin
      fails++;
      $display("FAIL areset_done: got ready=%b rd=%h/%h want 0/0/0", ready, rd_s0, rd_s1);
    end
    #1 g_resetn = 1'b1;
    check_idle_quiet(10, "areset_done_quiet");
    do_op(1'b0, 1'b1, 1'b0, 5'd16, 32'hCAFEBABE, 32'h01234567, 32'h0, r0, r1);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mask_b_shift_unit.md
Name: mask_b_shift_unit

Overview:
- Iterative, constant-time functional unit that executes boolean-masked shifts/rotates (SLLI, SRLI, RORI) on a two-share operand (rs1 = s0 XOR s1).
- Produces a freshly remasked two-share result. This is the producer side of the masked-shift check: the formal property unmasks rd and compares it against the shifted unmasked rs1.
- Sits in the masking ISE datapath beside the masked ALU. Issued by the execute stage with a valid/ready handshake.
- Shares are never combined inside the unit.

Parameters:
- XLEN, 32, operand and share width.
- SHW, 5, shift-amount width; the number of shift stages. Latency is SHW+1.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight operation.
- valid  in  1  request; held by the requester until ready is seen.
- op_slli  in  1  logical left shift.
- op_srli  in  1  logical right shift.
- op_rori  in  1  rotate right.
- shamt  in  SHW  shift amount (instruction bits 24:20).
- rs1_s0  in  XLEN  operand share 0.
- rs1_s1  in  XLEN  operand share 1.
- prng  in  XLEN  fresh randomness for the output remask.
- ready  out  1  result valid; a one-cycle pulse.
- rd_s0  out  XLEN  result share 0.
- rd_s1  out  XLEN  result share 1.

Behaviour:
- Reset (g_resetn low, asynchronous):
  - state=IDLE, step=0.
  - Both share registers, the latched shamt, op and prng cleared.
  - ready=0, rd_s0=0, rd_s1=0.
  - Reset mid-operation discards the operation with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On valid=1 and flush=0, latch rs1_s0, rs1_s1, shamt, op and prng; set step=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each cycle applies stage `step` to both shares independently, then step++.
  - Stage k with shamt[k]=1 shifts/rotates by 2^k.
  - Stage k with shamt[k]=0 passes the share unchanged, but is still clocked.
  - After stage SHW-1, register sh0^prng_l into rd_s0 and sh1^prng_l into rd_s1, then go to DONE.
- DONE: ready=1 for exactly one cycle, then return to IDLE unconditionally.
- Handshake:
  - Fixed latency: valid accepted in cycle 0 gives ready=1 in cycle SHW+1 (cycle 6 by default), independent of shamt.
  - The requester drops valid or presents a new request in the cycle after ready.
  - valid is only sampled in IDLE.
- Op select:
  - If multiple op bits are set, priority is rori > srli > slli.
  - If no op bit is set, the operation is a pass-through (shift 0) with full latency and remask.
- Shift semantics:
  - SLLI and SRLI zero-fill at share level. The fill is 0 in both shares, so the unmasked fill is 0.
  - RORI wraps bit 0 into bit XLEN-1 per share.
- Output gating: rd_s0 and rd_s1 are zero in every cycle where ready=0. The result registers are cleared on the cycle leaving DONE.
- Flush:
  - In SHIFT or DONE, forces IDLE next cycle, clears all share registers and rd outputs, and gives ready=0.
  - flush together with valid in IDLE: the request is not accepted.
- Correctness invariant: (rd_s0 ^ rd_s1) == op(rs1_s0 ^ rs1_s1, shamt) whenever ready=1.
- Remask invariant: rd_s0 == shifted(rs1_s0) ^ prng_l.

Test Plan:
- SLLI, shamt=4, rs1_s0=0xDEADBEEF, rs1_s1=0xDEADBEEE, prng=0xFFFFFFFF -> ready in cycle 6; rd_s0=0x1524110F, rd_s1=0x1524111F; XOR=0x00000010.
- SRLI, shamt=31, shares XOR to 0x80000000 (s0=0xC0000000, s1=0x40000000), prng=0x12345678 -> rd_s0^rd_s1=0x00000001; rd_s0=0x12345679.
- RORI, shamt=1, s0=0x00000003, s1=0x00000002, prng=0 -> rd_s0=0x80000001, rd_s1=0x00000001; XOR=0x80000000.
- shamt=0 and shamt=31 back-to-back -> ready exactly 6 cycles after each accept, and 1 cycle wide; rd zero outside ready.
- Flush asserted in cycle 3 of an op -> no ready pulse, outputs stay 0; a new request in the following IDLE cycle completes normally.
- g_resetn pulsed low mid-SHIFT (asynchronous, between edges) -> outputs zero immediately, state IDLE, and no stale ready after release.
